// File: rtl/dma_multichannel_engine.sv
// Multichannel single-word DMA engine: per-channel address/count registers,
// fixed or rotating DREQ arbitration, HRQ/HLDA hold handshake and bus strobes.
module dma_multichannel_engine #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned COUNT_W = 16
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [NUM_CH-1:0]         DREQ,
  input  logic                      HLDA,
  input  logic                      rotatePrio,
  input  logic                      cfgWrite,
  input  logic [$clog2(NUM_CH)-1:0] cfgCh,
  input  logic [ADDR_W-1:0]         cfgAddr,
  input  logic [COUNT_W-1:0]        cfgCount,
  input  logic [3:0]                cfgMode,
  input  logic                      cfgMask,
  output logic                      cfgReady,
  output logic                      HRQ,
  output logic [NUM_CH-1:0]         DACK,
  output logic                      AEN,
  output logic [ADDR_W-1:0]         ADDR,
  output logic                      IOR_N,
  output logic                      IOW_N,
  output logic                      MEMR_N,
  output logic                      MEMW_N,
  output logic                      EOP,
  output logic [NUM_CH-1:0]         tcStatus
);

  localparam int unsigned CH_W        = $clog2(NUM_CH);
  localparam logic [1:0]  XFER_IO2MEM = 2'b01;
  localparam logic [1:0]  XFER_MEM2IO = 2'b10;

  typedef enum logic [2:0] {ST_SI, ST_SO, ST_S1, ST_S2, ST_S4} state_t;

  state_t             state;
  logic [ADDR_W-1:0]  base_addr [NUM_CH];
  logic [ADDR_W-1:0]  cur_addr  [NUM_CH];
  logic [COUNT_W-1:0] base_cnt  [NUM_CH];
  logic [COUNT_W-1:0] cur_cnt   [NUM_CH];
  logic [3:0]         mode      [NUM_CH];
  logic [NUM_CH-1:0]  mask;
  logic [CH_W-1:0]    rot_ptr;
  logic [CH_W-1:0]    win_ch;

  logic [NUM_CH-1:0]  elig;
  logic [CH_W-1:0]    arb_ch;
  int unsigned        arb_idx;

  logic [1:0]         win_xfer;
  logic               win_auto;
  logic               win_dec;
  logic               tc_hit;
  logic [ADDR_W-1:0]  nxt_addr;

  // Scan from the highest offset down so the first eligible channel after the start point wins.
  always_comb begin
    elig    = DREQ & ~mask;
    arb_ch  = '0;
    arb_idx = 32'd0;
    for (int off = int'(NUM_CH) - 1; off >= 0; off--) begin
      arb_idx = (rotatePrio ? 32'(rot_ptr) : 32'd0) + 32'(off);
      if (arb_idx >= NUM_CH) arb_idx = arb_idx - NUM_CH;
      if (elig[CH_W'(arb_idx)]) arb_ch = CH_W'(arb_idx);
    end
  end

  assign win_xfer = mode[win_ch][1:0];
  assign win_auto = mode[win_ch][3];
  assign win_dec  = mode[win_ch][2];
  assign tc_hit   = (cur_cnt[win_ch] == '0);
  assign nxt_addr = win_dec ? cur_addr[win_ch] - ADDR_W'(1) : cur_addr[win_ch] + ADDR_W'(1);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= ST_SI;
      for (int i = 0; i < int'(NUM_CH); i++) begin
        base_addr[CH_W'(i)] <= '0;
        cur_addr[CH_W'(i)]  <= '0;
        base_cnt[CH_W'(i)]  <= '0;
        cur_cnt[CH_W'(i)]   <= '0;
        mode[CH_W'(i)]      <= '0;
      end
      mask     <= '1;
      tcStatus <= '0;
      rot_ptr  <= '0;
      win_ch   <= '0;
      cfgReady <= 1'b1;
      HRQ      <= 1'b0;
      DACK     <= '0;
      AEN      <= 1'b0;
      ADDR     <= '0;
      IOR_N    <= 1'b1;
      IOW_N    <= 1'b1;
      MEMR_N   <= 1'b1;
      MEMW_N   <= 1'b1;
      EOP      <= 1'b0;
    end else begin
      EOP <= 1'b0;
      case (state)
        ST_SI: begin
          if (cfgWrite) begin
            base_addr[cfgCh] <= cfgAddr;
            cur_addr[cfgCh]  <= cfgAddr;
            base_cnt[cfgCh]  <= cfgCount;
            cur_cnt[cfgCh]   <= cfgCount;
            mode[cfgCh]      <= cfgMode;
            mask[cfgCh]      <= cfgMask;
            tcStatus[cfgCh]  <= 1'b0;
          end else if (|elig) begin
            win_ch   <= arb_ch;
            state    <= ST_SO;
            HRQ      <= 1'b1;
            cfgReady <= 1'b0;
          end
        end
        ST_SO: begin
          if (HLDA) begin
            state <= ST_S1;
            AEN   <= 1'b1;
            ADDR  <= cur_addr[win_ch];
            DACK  <= NUM_CH'(1) << win_ch;
          end
        end
        ST_S1: begin
          state  <= ST_S2;
          IOR_N  <= ~(win_xfer == XFER_IO2MEM);
          MEMR_N <= ~(win_xfer == XFER_MEM2IO);
        end
        ST_S2: begin
          state  <= ST_S4;
          IOR_N  <= 1'b1;
          MEMR_N <= 1'b1;
          MEMW_N <= ~(win_xfer == XFER_IO2MEM);
          IOW_N  <= ~(win_xfer == XFER_MEM2IO);
          EOP    <= tc_hit;
        end
        ST_S4: begin
          state    <= ST_SI;
          HRQ      <= 1'b0;
          AEN      <= 1'b0;
          DACK     <= '0;
          IOW_N    <= 1'b1;
          MEMW_N   <= 1'b1;
          cfgReady <= 1'b1;
          cur_addr[win_ch] <= nxt_addr;
          cur_cnt[win_ch]  <= cur_cnt[win_ch] - COUNT_W'(1);
          // Terminal count: auto-init reloads (overriding the step above), otherwise self-mask.
          if (tc_hit) begin
            tcStatus[win_ch] <= 1'b1;
            if (win_auto) begin
              cur_addr[win_ch] <= base_addr[win_ch];
              cur_cnt[win_ch]  <= base_cnt[win_ch];
            end else begin
              mask[win_ch] <= 1'b1;
            end
          end
          rot_ptr <= (win_ch == CH_W'(NUM_CH - 1)) ? '0 : win_ch + CH_W'(1);
        end
        default: state <= ST_SI;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_multichannel_engine.sv
// Scoreboard bench for dma_multichannel_engine: a transaction-level model predicts each
// transfer (channel, address, strobes, EOP); a monitor checks every transfer the DUT runs.
module tb_dma_multichannel_engine;

  localparam int NCH = 4;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [3:0]  DREQ;
  logic        HLDA;
  logic        rotatePrio;
  logic        cfgWrite;
  logic [1:0]  cfgCh;
  logic [15:0] cfgAddr;
  logic [15:0] cfgCount;
  logic [3:0]  cfgMode;
  logic        cfgMask;
  logic        cfgReady, HRQ, AEN, IOR_N, IOW_N, MEMR_N, MEMW_N, EOP;
  logic [3:0]  DACK, tcStatus;
  logic [15:0] ADDR;

  logic hlda_fixed = 1'b1;
  logic hlda_rand  = 1'b0;
  logic hlda_r     = 1'b0;
  assign HLDA = hlda_rand ? hlda_r : hlda_fixed;

  always #5 CLK = ~CLK;

  dma_multichannel_engine #(.NUM_CH(NCH), .ADDR_W(16), .COUNT_W(16)) dut (
    .CLK(CLK), .RESET(RESET), .DREQ(DREQ), .HLDA(HLDA), .rotatePrio(rotatePrio),
    .cfgWrite(cfgWrite), .cfgCh(cfgCh), .cfgAddr(cfgAddr), .cfgCount(cfgCount),
    .cfgMode(cfgMode), .cfgMask(cfgMask), .cfgReady(cfgReady), .HRQ(HRQ), .DACK(DACK),
    .AEN(AEN), .ADDR(ADDR), .IOR_N(IOR_N), .IOW_N(IOW_N), .MEMR_N(MEMR_N),
    .MEMW_N(MEMW_N), .EOP(EOP), .tcStatus(tcStatus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] strb();
    return {IOR_N, IOW_N, MEMR_N, MEMW_N};
  endfunction

  typedef struct packed {
    logic [3:0]  dack;
    logic [15:0] addr;
    logic [3:0]  st2;
    logic [3:0]  st4;
    logic        eop;
  } xfer_t;

  xfer_t sb[$];

  // Reference model state
  logic [15:0] m_base_addr [NCH];
  logic [15:0] m_cur_addr  [NCH];
  logic [15:0] m_base_cnt  [NCH];
  logic [15:0] m_cur_cnt   [NCH];
  logic [3:0]  m_mode      [NCH];
  logic [3:0]  m_mask;
  logic [3:0]  m_tc;
  int          m_ptr;

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_base_addr[i] = 16'h0; m_cur_addr[i] = 16'h0;
      m_base_cnt[i]  = 16'h0; m_cur_cnt[i]  = 16'h0;
      m_mode[i]      = 4'h0;
    end
    m_mask = 4'hF;
    m_tc   = 4'h0;
    m_ptr  = 0;
  endtask

  task automatic cfg(input int ch, input logic [15:0] a, input logic [15:0] c,
                     input logic [3:0] md, input logic mk);
    @(negedge CLK);
    chk("cfg_ready", 32'(cfgReady), 32'd1);
    cfgWrite = 1'b1; cfgCh = 2'(ch); cfgAddr = a; cfgCount = c; cfgMode = md; cfgMask = mk;
    @(negedge CLK);
    cfgWrite = 1'b0;
    m_base_addr[ch] = a; m_cur_addr[ch] = a;
    m_base_cnt[ch]  = c; m_cur_cnt[ch]  = c;
    m_mode[ch]      = md;
    m_mask[ch]      = mk;
    m_tc[ch]        = 1'b0;
  endtask

  logic mon_en   = 1'b1;
  logic mon_busy = 1'b0;

  // Predict up to n transfers with DREQ held at dreq, then run them and drain.
  task automatic run_phase(input logic [3:0] dreq, input int n);
    logic [3:0] el, prev;
    int         np, ch, start, c, rises, cyc;
    xfer_t      x;
    np = 0;
    for (int k = 0; k < n; k++) begin
      el = dreq & ~m_mask;
      if (el == 4'h0) break;
      start = rotatePrio ? m_ptr : 0;
      ch = 0;
      for (int off = 0; off < NCH; off++) begin
        c = (start + off) % NCH;
        if (el[c]) begin ch = c; break; end
      end
      x.dack = 4'(1 << ch);
      x.addr = m_cur_addr[ch];
      case (m_mode[ch][1:0])
        2'b01:   begin x.st2 = 4'b0111; x.st4 = 4'b1110; end
        2'b10:   begin x.st2 = 4'b1101; x.st4 = 4'b1011; end
        default: begin x.st2 = 4'b1111; x.st4 = 4'b1111; end
      endcase
      x.eop = (m_cur_cnt[ch] == 16'h0);
      sb.push_back(x);
      m_cur_addr[ch] = m_mode[ch][2] ? m_cur_addr[ch] - 16'd1 : m_cur_addr[ch] + 16'd1;
      m_cur_cnt[ch]  = m_cur_cnt[ch] - 16'd1;
      if (x.eop) begin
        m_tc[ch] = 1'b1;
        if (m_mode[ch][3]) begin
          m_cur_addr[ch] = m_base_addr[ch];
          m_cur_cnt[ch]  = m_base_cnt[ch];
        end else begin
          m_mask[ch] = 1'b1;
        end
      end
      m_ptr = (ch + 1) % NCH;
      np++;
    end
    DREQ = dreq;
    if (np == 0) begin
      repeat (6) begin
        @(negedge CLK);
        chk("masked_no_hrq", 32'(HRQ), 32'd0);
      end
      DREQ = 4'h0;
      return;
    end
    prev = DACK; rises = 0; cyc = 0;
    while (rises < np && cyc < 80 * np) begin
      @(negedge CLK);
      cyc++;
      if (DACK != 4'h0 && prev == 4'h0) rises++;
      prev = DACK;
    end
    DREQ = 4'h0;
    chk("phase_xfers", 32'(rises), 32'(np));
    cyc = 0;
    while ((sb.size() != 0 || !cfgReady || mon_busy) && cyc < 60) begin
      @(negedge CLK);
      cyc++;
    end
    chk("phase_drain", 32'(sb.size()), 32'd0);
    sb.delete();
    chk("tc_status", 32'(tcStatus), 32'(m_tc));
  endtask

  // Monitor: capture S1/S2/S4 of every transfer and compare with the scoreboard head.
  initial begin
    logic [3:0]  prev, st1, dack4;
    logic [15:0] addr4;
    logic [2:0]  aen3, hrq3, eop3;
    xfer_t       o, e;
    prev = 4'h0;
    forever begin
      @(negedge CLK);
      if (mon_en && !RESET && DACK != 4'h0 && prev == 4'h0) begin
        mon_busy = 1'b1;
        o.dack = DACK; o.addr = ADDR; st1 = strb();
        aen3[2] = AEN; hrq3[2] = HRQ; eop3[2] = EOP;
        @(negedge CLK);
        o.st2 = strb(); aen3[1] = AEN; hrq3[1] = HRQ; eop3[1] = EOP;
        @(negedge CLK);
        o.st4 = strb(); aen3[0] = AEN; hrq3[0] = HRQ; eop3[0] = EOP; o.eop = EOP;
        dack4 = DACK; addr4 = ADDR;
        chk("xfer_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("xfer_dack", 32'(o.dack), 32'(e.dack));
          chk("xfer_addr", 32'(o.addr), 32'(e.addr));
          chk("xfer_dack_held", 32'(dack4), 32'(e.dack));
          chk("xfer_addr_held", 32'(addr4), 32'(e.addr));
          chk("xfer_s1_strobes", 32'(st1), 32'hF);
          chk("xfer_s2_strobes", 32'(o.st2), 32'(e.st2));
          chk("xfer_s4_strobes", 32'(o.st4), 32'(e.st4));
          chk("xfer_eop", 32'(eop3), 32'({2'b00, e.eop}));
          chk("xfer_aen", 32'(aen3), 32'h7);
          chk("xfer_hrq", 32'(hrq3), 32'h7);
        end
        mon_busy = 1'b0;
      end
      prev = DACK;
    end
  end

  initial forever begin
    @(negedge CLK);
    hlda_r = 1'($urandom_range(0, 1));
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cfg_ready"}, 32'(cfgReady), 32'd1);
    chk({tag, "_hrq"}, 32'(HRQ), 32'd0);
    chk({tag, "_dack"}, 32'(DACK), 32'd0);
    chk({tag, "_aen"}, 32'(AEN), 32'd0);
    chk({tag, "_addr"}, 32'(ADDR), 32'd0);
    chk({tag, "_strobes"}, 32'(strb()), 32'hF);
    chk({tag, "_eop"}, 32'(EOP), 32'd0);
    chk({tag, "_tc"}, 32'(tcStatus), 32'd0);
  endtask

  initial begin
    RESET = 1'b1; DREQ = 4'hF; rotatePrio = 1'b0; cfgWrite = 1'b0; cfgCh = 2'd0;
    cfgAddr = 16'h0; cfgCount = 16'h0; cfgMode = 4'h0; cfgMask = 1'b0;
    model_reset();
    repeat (3) @(negedge CLK);
    chk_reset_outputs("reset");
    RESET = 1'b0;
    repeat (5) begin
      @(negedge CLK);
      chk("post_reset_no_hrq", 32'(HRQ), 32'd0);
    end
    DREQ = 4'h0;

    // ch0 IO->mem, three transfers, terminal count masks it
    cfg(0, 16'h1000, 16'd2, 4'b0001, 1'b0);
    run_phase(4'b0001, 3);
    chk("ch0_tc_flag", 32'(tcStatus[0]), 32'd1);
    run_phase(4'b0001, 2);

    // fixed then rotating priority
    for (int ch = 0; ch < NCH; ch++) cfg(ch, 16'(16'h2000 + ch * 16'h100), 16'd20, 4'b0010, 1'b0);
    rotatePrio = 1'b0;
    run_phase(4'b1110, 1);
    rotatePrio = 1'b1;
    run_phase(4'b1111, 5);
    rotatePrio = 1'b0;

    // auto-init with decrement, count 0: EOP every time, never masked
    cfg(1, 16'h0000, 16'd0, 4'b1101, 1'b0);
    run_phase(4'b0010, 3);

    // address wrap
    cfg(2, 16'hFFFF, 16'd1, 4'b0001, 1'b0);
    run_phase(4'b0100, 2);

    // hold handshake stall, then reset during S2
    cfg(3, 16'h3000, 16'd5, 4'b0001, 1'b0);
    hlda_fixed = 1'b0; mon_en = 1'b0;
    @(negedge CLK);
    chk("hrq_idle", 32'(HRQ), 32'd0);
    DREQ = 4'b1000;
    @(negedge CLK);
    chk("dreq_hrq_latency", 32'(HRQ), 32'd1);
    DREQ = 4'h0;
    repeat (20) begin
      @(negedge CLK);
      chk("so_wait_hrq", 32'(HRQ), 32'd1);
      chk("so_wait_dack", 32'(DACK), 32'd0);
    end
    hlda_fixed = 1'b1;
    @(negedge CLK);
    chk("hlda_dack_latency", 32'(DACK), 32'h8);
    @(negedge CLK);
    chk("s2_ior", 32'(IOR_N), 32'd0);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    model_reset();
    chk_reset_outputs("midxfer_reset");
    mon_en = 1'b1;
    run_phase(4'b1111, 1);

    // randomized configurations, request patterns, priority mode and HLDA
    hlda_rand = 1'b1;
    for (int it = 0; it < 30; it++) begin
      repeat (2) begin
        if ($urandom_range(0, 1) == 1)
          cfg(int'($urandom_range(0, NCH - 1)), 16'($urandom), 16'($urandom_range(0, 3)),
              4'($urandom), 1'($urandom_range(0, 3) == 0));
      end
      @(negedge CLK);
      rotatePrio = 1'($urandom_range(0, 1));
      run_phase(4'($urandom), int'($urandom_range(1, 6)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
